sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM between two requesters: the SLC-3 CPU memory port and the memory-init/debug loader port.
- Sequences each access as a fixed multi-cycle SRAM read or write with active-low strobes.
- Sits in the toplevel between the slc3 datapath's memory interface and the SRAM pins.
- Uses a one-cycle-pulse acknowledge handshake per port and round-robin arbitration on contention.

Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM strobes are held per access (legal range 1..15).
- ADDR_W, 20, SRAM address width.

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU requests an access; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled at grant
- cpu_addr  in  ADDR_W  CPU address; sampled at grant
- cpu_wdata  in  16  CPU write data; sampled at grant
- cpu_rdata  out  16  read data returned to the CPU; valid while cpu_ack=1 and held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- init_req, init_we, init_addr, init_wdata, init_rdata, init_ack  (same directions and widths as the cpu_* ports)  loader port
- CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low
- ADDR  out  ADDR_W  SRAM address
- Data_to_SRAM  out  16  write data for the toplevel tri-state buffer
- Data_drive  out  1  1 = toplevel drives the Data bus with Data_to_SRAM
- Data_from_SRAM  in  16  SRAM data bus input

Behaviour:
- States: IDLE, ACCESS, DONE. All outputs are registered.
- Reset values:
  - state = IDLE; CE = OE = WE = UB = LB = 1; ADDR = 0; Data_to_SRAM = 0; Data_drive = 0.
  - cpu_ack = init_ack = 0; cpu_rdata = init_rdata = 0.
  - last_grant = INIT, so the CPU wins the first tie.
- IDLE:
  - No request: stay in IDLE, strobes inactive.
  - One request: grant it.
  - Both requests: grant the port not equal to last_grant.
  - On grant: latch owner, we, addr and wdata; update last_grant; load the wait counter with WAIT_CYCLES-1; go to ACCESS.
- ACCESS, for exactly WAIT_CYCLES cycles:
  - CE = 0, UB = LB = 0, ADDR = latched address.
  - Read: OE = 0, WE = 1, Data_drive = 0.
  - Write: OE = 1, WE = 0, Data_drive = 1, Data_to_SRAM = latched wdata.
  - The counter decrements each cycle. On the cycle the counter is 0:
    - a read captures Data_from_SRAM into the owner's rdata register;
    - the state goes to DONE.
- DONE, one cycle:
  - All strobes inactive; Data_drive = 0.
  - Owner's ack = 1 for this cycle only.
  - Next state is IDLE. DONE never grants.
- Latency:
  - A request seen in IDLE at edge N holds the strobes asserted for cycles N+1..N+WAIT_CYCLES.
  - The ack is high in cycle N+WAIT_CYCLES+1.
  - Earliest next grant is at edge N+WAIT_CYCLES+2.
  - Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Handshake:
  - A requester must deassert req in the cycle after its ack.
  - A req still high when the state returns to IDLE is treated as a new request.
  - Changes to addr, we or wdata after grant are ignored.
  - rdata of the non-owner port is never modified.
- Simultaneous events:
  - A request arriving while another access is in progress waits in IDLE arbitration.
  - Both ports are never acked in the same cycle.
  - An alternating tie always alternates grants.
- Reset mid-operation:
  - The next edge forces all reset values.
  - The in-flight access is aborted and no ack is issued.
  - rdata registers clear to 0.
  - WE returns high in the same cycle Data_drive drops.
- Invariants:
  - WE = 0 implies CE = 0, OE = 1 and Data_drive = 1.
  - OE = 0 implies WE = 1 and Data_drive = 0.

Test Plan:
- Reset, then CPU read of addr 0x00031 with Data_from_SRAM = 0x1234 and WAIT_CYCLES = 2 → CE/OE low for exactly 2 cycles, ADDR = 0x00031, cpu_ack pulses 1 cycle in the 3rd cycle after grant, cpu_rdata = 0x1234.
- Init write addr 0x0005A with data 0xA0A0 → WE low for 2 cycles, Data_drive = 1, Data_to_SRAM = 0xA0A0, OE stays 1, single init_ack, cpu_ack stays 0.
- cpu_req and init_req both asserted from reset and held for 4 accesses → grant order CPU, INIT, CPU, INIT; acks spaced 4 cycles apart.
- Change cpu_addr from 0x00010 to 0x00020 during ACCESS → ADDR remains 0x00010 throughout.
- Reset asserted in the 1st ACCESS cycle of a write → next cycle all strobes = 1, Data_drive = 0, no ack, state IDLE.
- Rerun the CPU read scenario with WAIT_CYCLES = 1 and with WAIT_CYCLES = 15 → strobe width 1 and 15 cycles respectively; ack latency WAIT_CYCLES+1 after grant.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: round-robin sharing of one 16-bit SRAM between the CPU and loader ports with fixed-length strobed accesses
module sram_access_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  input  logic              init_req,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [15:0]       init_wdata,
  output logic [15:0]       init_rdata,
  output logic              init_ack,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] ADDR,
  output logic [15:0]       Data_to_SRAM,
  output logic              Data_drive,
  input  logic [15:0]       Data_from_SRAM
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic owner, owner_n, lwe, lwe_n, last, last_n, gi, act, cpu_ack_n, init_ack_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0] dts_n, cpu_rdata_n, init_rdata_n;
  always_comb begin
    gi = init_req & (~cpu_req | ~last);
    state_n = state;
    cnt_n = cnt;
    owner_n = owner;
    lwe_n = lwe;
    last_n = last;
    addr_n = ADDR;
    dts_n = Data_to_SRAM;
    cpu_rdata_n = cpu_rdata;
    init_rdata_n = init_rdata;
    cpu_ack_n = 1'b0;
    init_ack_n = 1'b0;
    act = 1'b0;
    if (state == IDLE && (cpu_req || init_req)) begin
      state_n = ACCESS;
      cnt_n = 4'(WAIT_CYCLES - 1);
      owner_n = gi;
      last_n = gi;
      lwe_n = gi ? init_we : cpu_we;
      addr_n = gi ? init_addr : cpu_addr;
      dts_n = gi ? init_wdata : cpu_wdata;
      act = 1'b1;
    end else if (state == ACCESS && cnt == 4'd0) begin
      state_n = DONE;
      cpu_ack_n = ~owner;
      init_ack_n = owner;
      cpu_rdata_n = (!lwe && !owner) ? Data_from_SRAM : cpu_rdata;
      init_rdata_n = (!lwe && owner) ? Data_from_SRAM : init_rdata;
    end else if (state == ACCESS) begin
      cnt_n = cnt - 4'd1;
      act = 1'b1;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      owner <= 1'b0;
      lwe <= 1'b0;
      last <= 1'b1;
      {CE, UB, LB, OE, WE} <= 5'b11111;
      Data_drive <= 1'b0;
      ADDR <= '0;
      Data_to_SRAM <= 16'd0;
      cpu_rdata <= 16'd0;
      init_rdata <= 16'd0;
      cpu_ack <= 1'b0;
      init_ack <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      owner <= owner_n;
      lwe <= lwe_n;
      last <= last_n;
      {CE, UB, LB} <= {3{~act}};
      OE <= ~(act & ~lwe_n);
      WE <= ~(act & lwe_n);
      Data_drive <= act & lwe_n;
      ADDR <= addr_n;
      Data_to_SRAM <= dts_n;
      cpu_rdata <= cpu_rdata_n;
      init_rdata <= init_rdata_n;
      cpu_ack <= cpu_ack_n;
      init_ack <= init_ack_n;
    end
  end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: vector table on a WAIT_CYCLES=2 arbiter plus strobe-width/latency checks at 1, 2 and 15
module tb_sram_access_arbiter;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset, cpu_req, cpu_we, init_req, init_we;
  logic [19:0] cpu_addr, init_addr;
  logic [15:0] cpu_wdata, init_wdata, Data_from_SRAM;
  logic [15:0] cpu_rdata [3], init_rdata [3], dts [3];
  logic [19:0] addr [3];
  logic cpu_ack [3], init_ack [3], ce [3], oe [3], we [3], ub [3], lb [3], drv [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_access_arbiter #(.WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15)), .ADDR_W(20)) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
      .init_req(init_req), .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
      .init_rdata(init_rdata[g]), .init_ack(init_ack[g]),
      .CE(ce[g]), .OE(oe[g]), .WE(we[g]), .UB(ub[g]), .LB(lb[g]),
      .ADDR(addr[g]), .Data_to_SRAM(dts[g]), .Data_drive(drv[g]), .Data_from_SRAM(Data_from_SRAM)
    );
  end
  typedef struct {
    logic rst, creq, cwe;
    logic [19:0] caddr;
    logic [15:0] cwd;
    logic ireq, iwe;
    logic [19:0] iaddr;
    logic [15:0] iwd, din;
    logic [5:0] sig;
    logic [19:0] eaddr;
    logic [15:0] edts, ecrd, eird;
  } vec_t;
  vec_t tbl [$];
  int nvec = 0, nmis = 0;
  int lo [3], at [3];
  logic [15:0] crd, ird;
  function automatic void add(logic rst, logic creq, logic cwe, logic [19:0] caddr, logic [15:0] cwd,
                              logic ireq, logic iwe, logic [19:0] iaddr, logic [15:0] iwd, logic [15:0] din,
                              logic [5:0] sig, logic [19:0] eaddr, logic [15:0] edts, logic [15:0] ecrd,
                              logic [15:0] eird);
    tbl.push_back('{rst, creq, cwe, caddr, cwd, ireq, iwe, iaddr, iwd, din, sig, eaddr, edts, ecrd, eird});
  endfunction
  task automatic check(input int i, input vec_t v);
    logic [5:0] s;
    logic ok;
    s = {ce[0], oe[0], we[0], drv[0], cpu_ack[0], init_ack[0]};
    ok = s == v.sig && ub[0] == v.sig[5] && lb[0] == v.sig[5] && cpu_rdata[0] == v.ecrd &&
         init_rdata[0] == v.eird && (v.sig[5] || addr[0] == v.eaddr) && (!v.sig[2] || dts[0] == v.edts);
    nvec++;
    if (!ok) begin
      nmis++;
      $display("FAIL vec%0d: got sig=%b ublb=%b%b addr=%h dts=%h crd=%h ird=%h, expected sig=%b addr=%h dts=%h crd=%h ird=%h",
               i, s, ub[0], lb[0], addr[0], dts[0], cpu_rdata[0], init_rdata[0], v.sig, v.eaddr, v.edts, v.ecrd, v.eird);
    end
  endtask
  initial begin
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 6'b111000, 0, 0, 0, 0);
    add(0, 1, 0, 20'h31, 16'h5555, 0, 0, 0, 0, 16'h1234, 6'b001000, 20'h31, 0, 0, 0);
    add(0, 1, 0, 20'h31, 16'h5555, 0, 0, 0, 0, 16'h1234, 6'b001000, 20'h31, 0, 0, 0);
    add(0, 1, 0, 20'h31, 16'h5555, 0, 0, 0, 0, 16'h1234, 6'b111010, 0, 0, 16'h1234, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 6'b111000, 0, 0, 16'h1234, 0);
    add(0, 0, 0, 0, 0, 1, 1, 20'h5A, 16'hA0A0, 16'h7777, 6'b010100, 20'h5A, 16'hA0A0, 16'h1234, 0);
    add(0, 0, 0, 0, 0, 1, 1, 20'h5A, 16'hA0A0, 16'h7777, 6'b010100, 20'h5A, 16'hA0A0, 16'h1234, 0);
    add(0, 0, 0, 0, 0, 1, 1, 20'h5A, 16'hA0A0, 16'h7777, 6'b111001, 0, 0, 16'h1234, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h7777, 6'b111000, 0, 0, 16'h1234, 0);
    add(1, 1, 0, 20'h100, 0, 1, 0, 20'h200, 0, 0, 6'b111000, 0, 0, 0, 0);
    crd = 0;
    ird = 0;
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 0, 20'h100, 0, 1, 0, 20'h200, 0, 0, 6'b001000, k[0] ? 20'h200 : 20'h100, 0, crd, ird);
      add(0, 1, 0, 20'h100, 0, 1, 0, 20'h200, 0, 0, 6'b001000, k[0] ? 20'h200 : 20'h100, 0, crd, ird);
      if (k[0]) ird = 16'h1000 + 16'(k);
      else crd = 16'h1000 + 16'(k);
      add(0, 1, 0, 20'h100, 0, 1, 0, 20'h200, 0, 16'h1000 + 16'(k), k[0] ? 6'b111001 : 6'b111010, 0, 0, crd, ird);
      add(0, 1, 0, 20'h100, 0, 1, 0, 20'h200, 0, 0, 6'b111000, 0, 0, crd, ird);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111000, 0, 0, 16'h1002, 16'h1003);
    add(0, 1, 0, 20'h10, 0, 0, 0, 0, 0, 16'h4242, 6'b001000, 20'h10, 0, 16'h1002, 16'h1003);
    add(0, 1, 1, 20'h20, 16'hFFFF, 0, 0, 0, 0, 16'h4242, 6'b001000, 20'h10, 0, 16'h1002, 16'h1003);
    add(0, 1, 1, 20'h20, 16'hFFFF, 0, 0, 0, 0, 16'h4242, 6'b111010, 0, 0, 16'h4242, 16'h1003);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h4242, 6'b111000, 0, 0, 16'h4242, 16'h1003);
    add(0, 0, 0, 0, 0, 1, 1, 20'h77, 16'h3C3C, 0, 6'b010100, 20'h77, 16'h3C3C, 16'h4242, 16'h1003);
    add(1, 0, 0, 0, 0, 1, 1, 20'h77, 16'h3C3C, 0, 6'b111000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111000, 0, 0, 0, 0);
    Reset = 1'b1;
    {cpu_req, cpu_we, init_req, init_we} = 4'b0;
    {cpu_addr, init_addr, cpu_wdata, init_wdata, Data_from_SRAM} = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      Reset = tbl[i].rst;
      cpu_req = tbl[i].creq;
      cpu_we = tbl[i].cwe;
      cpu_addr = tbl[i].caddr;
      cpu_wdata = tbl[i].cwd;
      init_req = tbl[i].ireq;
      init_we = tbl[i].iwe;
      init_addr = tbl[i].iaddr;
      init_wdata = tbl[i].iwd;
      Data_from_SRAM = tbl[i].din;
      @(posedge Clk);
      #1;
      check(i, tbl[i]);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 20'h31;
    Data_from_SRAM = 16'h1234;
    lo = '{0, 0, 0};
    at = '{-1, -1, -1};
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk);
      #1;
      for (int k = 0; k < 3; k++)
        if (at[k] < 0) begin
          if (!ce[k]) lo[k]++;
          if (cpu_ack[k]) at[k] = c;
        end
    end
    cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = k == 0 ? 2 : (k == 1 ? 1 : 15);
      nvec++;
      if (lo[k] != w || at[k] != w || cpu_rdata[k] != 16'h1234) begin
        nmis++;
        $display("FAIL width_w%0d: got strobe=%0d ack_after=%0d rdata=%h, expected strobe=%0d ack_after=%0d rdata=1234",
                 w, lo[k], at[k], cpu_rdata[k], w, w);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
